// File: rtl/bram_sdp_split_arbiter.sv
// Two-client arbiter for one simple-dual-port BRAM half: independent round-robin write/read ports.
// Optional macro BRAM_SDP_SPLIT_ARB_BYPASS_EN returns freshly written data on same-address collisions.
module bram_sdp_split_arbiter #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wreq_0,
    input  logic              wreq_1,
    input  logic [AWIDTH-1:0] wa_0,
    input  logic [AWIDTH-1:0] wa_1,
    input  logic [DWIDTH-1:0] wd_0,
    input  logic [DWIDTH-1:0] wd_1,
    output logic              wgnt_0,
    output logic              wgnt_1,
    input  logic              rreq_0,
    input  logic              rreq_1,
    input  logic [AWIDTH-1:0] ra_0,
    input  logic [AWIDTH-1:0] ra_1,
    output logic              rgnt_0,
    output logic              rgnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DWIDTH-1:0] rdata,
    output logic              mem_wce,
    output logic [AWIDTH-1:0] mem_wa,
    output logic [DWIDTH-1:0] mem_wd,
    output logic              mem_rce,
    output logic [AWIDTH-1:0] mem_ra,
    input  logic [DWIDTH-1:0] mem_rq
);

    logic              wptr_reg;
    logic              rptr_reg;
    logic              rtag_reg;
    logic [DWIDTH-1:0] rdata_hold_reg;
    logic [DWIDTH-1:0] rdata_sel;
    logic              rvalid_any;

    // Pointer names the client that wins when both request.
    always_comb begin
        wgnt_0 = 1'b0;
        wgnt_1 = 1'b0;
        if (!rst) begin
            if (wreq_0 && (!wreq_1 || !wptr_reg))
                wgnt_0 = 1'b1;
            else if (wreq_1)
                wgnt_1 = 1'b1;
        end
    end

    always_comb begin
        rgnt_0 = 1'b0;
        rgnt_1 = 1'b0;
        if (!rst) begin
            if (rreq_0 && (!rreq_1 || !rptr_reg))
                rgnt_0 = 1'b1;
            else if (rreq_1)
                rgnt_1 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg <= 1'b0;
            rptr_reg <= 1'b0;
        end else begin
            if (wgnt_0)
                wptr_reg <= 1'b1;
            else if (wgnt_1)
                wptr_reg <= 1'b0;
            if (rgnt_0)
                rptr_reg <= 1'b1;
            else if (rgnt_1)
                rptr_reg <= 1'b0;
        end
    end

    // Write port: address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wce <= 1'b0;
            mem_wa  <= '0;
            mem_wd  <= '0;
        end else begin
            mem_wce <= wgnt_0 | wgnt_1;
            if (wgnt_0) begin
                mem_wa <= wa_0;
                mem_wd <= wd_0;
            end else if (wgnt_1) begin
                mem_wa <= wa_1;
                mem_wd <= wd_1;
            end
        end
    end

    // Read port: mem_rce doubles as the in-flight valid bit, rtag_reg names the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rce  <= 1'b0;
            mem_ra   <= '0;
            rtag_reg <= 1'b0;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
        end else begin
            mem_rce  <= rgnt_0 | rgnt_1;
            rtag_reg <= rgnt_1;
            if (rgnt_0)
                mem_ra <= ra_0;
            else if (rgnt_1)
                mem_ra <= ra_1;
            rvalid_0 <= mem_rce & ~rtag_reg;
            rvalid_1 <= mem_rce & rtag_reg;
        end
    end

`ifdef BRAM_SDP_SPLIT_ARB_BYPASS_EN
    logic              byp_reg;
    logic [DWIDTH-1:0] byp_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_reg      <= 1'b0;
            byp_data_reg <= '0;
        end else begin
            byp_reg      <= mem_wce & mem_rce & (mem_wa == mem_ra);
            byp_data_reg <= mem_wd;
        end
    end

    assign rdata_sel = byp_reg ? byp_data_reg : mem_rq;
`else
    assign rdata_sel = mem_rq;
`endif

    // mem_rq is only meaningful in the rvalid cycle, so the last result is held locally.
    assign rvalid_any = rvalid_0 | rvalid_1;
    assign rdata      = rvalid_any ? rdata_sel : rdata_hold_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_hold_reg <= '0;
        else if (rvalid_any)
            rdata_hold_reg <= rdata_sel;
    end

endmodule

// File: tb/tb_bram_sdp_split_arbiter.sv
// Randomized and directed bench for bram_sdp_split_arbiter against a transaction-level reference model.
module tb_bram_sdp_split_arbiter;
    localparam int AW = 10;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wreq_0 = 0, wreq_1 = 0, rreq_0 = 0, rreq_1 = 0;
    logic [AW-1:0] wa_0 = '0, wa_1 = '0, ra_0 = '0, ra_1 = '0;
    logic [DW-1:0] wd_0 = '0, wd_1 = '0;
    logic          wgnt_0, wgnt_1, rgnt_0, rgnt_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata;
    logic          mem_wce, mem_rce;
    logic [AW-1:0] mem_wa, mem_ra;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rq = '0;

    bram_sdp_split_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .wreq_0(wreq_0), .wreq_1(wreq_1), .wa_0(wa_0), .wa_1(wa_1), .wd_0(wd_0), .wd_1(wd_1),
        .wgnt_0(wgnt_0), .wgnt_1(wgnt_1),
        .rreq_0(rreq_0), .rreq_1(rreq_1), .ra_0(ra_0), .ra_1(ra_1),
        .rgnt_0(rgnt_0), .rgnt_1(rgnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .rdata(rdata),
        .mem_wce(mem_wce), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_rce(mem_rce), .mem_ra(mem_ra), .mem_rq(mem_rq)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 4) return 18'h00001;
        return 18'(a * 17);
    endfunction

    // Behavioural BRAM: unwritten locations read their preload value.
    bit [DW-1:0] bram    [1024];
    bit          written [1024];
    always @(posedge clk) begin
        if (mem_rce) mem_rq <= written[mem_ra] ? bram[mem_ra] : init_val(int'(mem_ra));
        if (mem_wce) begin
            bram[mem_wa]    <= mem_wd;
            written[mem_wa] <= 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: contents as seen by the clients, pointers, expected port values.
    logic [DW-1:0] sm [1024];
    bit            wptr_m, rptr_m;
    logic          e_wce, e_rce;
    logic [AW-1:0] e_wa, e_ra;
    logic [DW-1:0] e_wd, e_rdata;
    bit            s1_v, s1_c, s2_v, s2_c;
    logic [DW-1:0] s1_d, s2_d;
    bit            g_w0, g_w1, g_r0, g_r1;
    int            cyc = 0;

    function automatic int pick(input bit r0, input bit r1, input bit ptr);
        if (r0 && r1) return int'(ptr);
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        wptr_m = 0; rptr_m = 0;
        e_wce = 0; e_rce = 0; e_wa = '0; e_ra = '0; e_wd = '0; e_rdata = '0;
        s1_v = 0; s1_c = 0; s1_d = '0; s2_v = 0; s2_c = 0; s2_d = '0;
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic tick();
        int            ww, wr;
        logic [AW-1:0] waddr, raddr;
        logic [DW-1:0] wdat, rd;
        #1;
        ww = pick(wreq_0, wreq_1, wptr_m);
        wr = pick(rreq_0, rreq_1, rptr_m);
        chk("wgnt_0", 32'(wgnt_0), 32'(ww == 0));
        chk("wgnt_1", 32'(wgnt_1), 32'(ww == 1));
        chk("rgnt_0", 32'(rgnt_0), 32'(wr == 0));
        chk("rgnt_1", 32'(rgnt_1), 32'(wr == 1));
        waddr = (ww == 1) ? wa_1 : wa_0;
        wdat  = (ww == 1) ? wd_1 : wd_0;
        raddr = (wr == 1) ? ra_1 : ra_0;
        rd    = sm[raddr];
`ifdef BRAM_SDP_SPLIT_ARB_BYPASS_EN
        if (ww >= 0 && wr >= 0 && waddr == raddr) rd = wdat;
`endif
        if (ww >= 0) begin
            sm[waddr] = wdat;
            wptr_m = (ww == 0);
            $display("cyc %0d write client=%0d addr=%0h data=%0h", cyc, ww, waddr, wdat);
        end
        if (wr >= 0) begin
            rptr_m = (wr == 0);
            $display("cyc %0d read  client=%0d addr=%0h exp=%0h", cyc, wr, raddr, rd);
        end
        g_w0 = (ww == 0); g_w1 = (ww == 1); g_r0 = (wr == 0); g_r1 = (wr == 1);
        @(posedge clk);
        #1;
        cyc++;
        e_wce = (ww >= 0);
        if (ww >= 0) begin e_wa = waddr; e_wd = wdat; end
        e_rce = (wr >= 0);
        if (wr >= 0) e_ra = raddr;
        s2_v = s1_v; s2_c = s1_c; s2_d = s1_d;
        s1_v = (wr >= 0); s1_c = (wr == 1); s1_d = rd;
        if (s2_v) e_rdata = s2_d;
        chk("mem_wce", 32'(mem_wce), 32'(e_wce));
        chk("mem_wa", 32'(mem_wa), 32'(e_wa));
        chk("mem_wd", 32'(mem_wd), 32'(e_wd));
        chk("mem_rce", 32'(mem_rce), 32'(e_rce));
        chk("mem_ra", 32'(mem_ra), 32'(e_ra));
        chk("rvalid_0", 32'(rvalid_0), 32'(s2_v && !s2_c));
        chk("rvalid_1", 32'(rvalid_1), 32'(s2_v && s2_c));
        chk("rdata", 32'(rdata), 32'(e_rdata));
    endtask

    task automatic idle();
        wreq_0 = 0; wreq_1 = 0; rreq_0 = 0; rreq_1 = 0;
    endtask

    task automatic check_cleared();
        chk("rst_mem_wce", 32'(mem_wce), 32'(0));
        chk("rst_mem_wa", 32'(mem_wa), 32'(0));
        chk("rst_mem_wd", 32'(mem_wd), 32'(0));
        chk("rst_mem_rce", 32'(mem_rce), 32'(0));
        chk("rst_mem_ra", 32'(mem_ra), 32'(0));
        chk("rst_rvalid", 32'({rvalid_1, rvalid_0}), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sm[i] = init_val(i);
        model_reset();
        // Grants must stay low while reset is asserted.
        wreq_0 = 1; rreq_1 = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("gnt_in_reset", 32'({wgnt_1, wgnt_0, rgnt_1, rgnt_0}), 32'(0));
        check_cleared();
        rst = 0;
        idle();

        // Contention: both writers for 4 cycles, then idle, then one more contended cycle.
        wreq_0 = 1; wreq_1 = 1; wa_0 = 10'd20; wa_1 = 10'd21; wd_0 = 18'h0AAAA; wd_1 = 18'h05555;
        repeat (4) tick();
        idle(); tick();
        wreq_0 = 1; wreq_1 = 1; tick();
        idle(); tick();

        // Single write to address 5.
        wreq_0 = 1; wa_0 = 10'd5; wd_0 = 18'h2A5A3; tick();
        idle(); tick();

        // Pipelined reads by client 1 at addresses 1..3.
        for (int i = 1; i <= 3; i++) begin
            rreq_1 = 1; ra_1 = 10'(i); tick();
        end
        idle(); repeat (2) tick();

        // Write and read granted together at different addresses.
        wreq_0 = 1; wa_0 = 10'd7; wd_0 = 18'h12345; rreq_1 = 1; ra_1 = 10'd9; tick();
        idle(); repeat (2) tick();

        // Same-address collision at address 4.
        wreq_0 = 1; wa_0 = 10'd4; wd_0 = 18'h3FFFF; rreq_1 = 1; ra_1 = 10'd4; tick();
        idle(); repeat (3) tick();

        // Randomized traffic honouring hold-until-granted.
        for (int n = 0; n < 300; n++) begin
            if (!(wreq_0 && !g_w0)) begin
                wreq_0 = 1'($urandom_range(0, 1)); wa_0 = 10'($urandom_range(0, 15)); wd_0 = 18'($urandom);
            end
            if (!(wreq_1 && !g_w1)) begin
                wreq_1 = 1'($urandom_range(0, 1)); wa_1 = 10'($urandom_range(0, 15)); wd_1 = 18'($urandom);
            end
            if (!(rreq_0 && !g_r0)) begin
                rreq_0 = 1'($urandom_range(0, 1)); ra_0 = 10'($urandom_range(0, 15));
            end
            if (!(rreq_1 && !g_r1)) begin
                rreq_1 = 1'($urandom_range(0, 1)); ra_1 = 10'($urandom_range(0, 15));
            end
            tick();
        end
        idle(); repeat (3) tick();

        // Reset mid-read: leave both pointers at client 1 first, then pulse reset after a read grant.
        wreq_0 = 1; wa_0 = 10'd30; wd_0 = 18'h00777; tick();
        idle();
        rreq_0 = 1; ra_0 = 10'd2; tick();
        idle();
        rst = 1;
        #1;
        model_reset();
        check_cleared();
        chk("gnt_rst_pulse", 32'({wgnt_1, wgnt_0, rgnt_1, rgnt_0}), 32'(0));
        #1;
        rst = 0;
        tick();
        chk("no_rvalid_after_rst", 32'({rvalid_1, rvalid_0}), 32'(0));
        wreq_0 = 1; wreq_1 = 1; rreq_0 = 1; rreq_1 = 1;
        wa_0 = 10'd40; wa_1 = 10'd41; ra_0 = 10'd1; ra_1 = 10'd3;
        #1;
        chk("post_rst_wgnt0", 32'(wgnt_0), 32'(1));
        chk("post_rst_rgnt0", 32'(rgnt_0), 32'(1));
        tick();
        idle(); repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
